// File: rtl/w5500_pkg.sv
// Shared definitions for the W5500 socket transmit path: register map,
// command/status codes, control-byte helpers and state encodings.
package w5500_pkg;

    localparam logic [15:0] SN_CR    = 16'h0001;
    localparam logic [15:0] SN_IR    = 16'h0002;
    localparam logic [15:0] SN_TX_WR = 16'h0024;

    localparam logic [7:0]  CMD_SEND   = 8'h20;
    localparam int          IR_SEND_OK = 4;
    localparam int          IR_TIMEOUT = 3;

    localparam logic [1:0]  SEL_SOCK_REG = 2'd1;
    localparam logic [1:0]  SEL_TX_BUF   = 2'd2;
    localparam logic        RWB_READ     = 1'b0;
    localparam logic        RWB_WRITE    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_PTR, ST_WR_DATA, ST_WR_PTR,
        ST_WR_CMD, ST_POLL, ST_CLR_IR, ST_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        FR_IDLE, FR_SETUP, FR_BYTE, FR_WAIT, FR_GAP
    } frame_state_t;

    // Block select = sock*4 + sel.
    function automatic logic [4:0] bsb(input logic [2:0] sock, input logic [1:0] sel);
        return {sock, sel};
    endfunction

    function automatic logic [7:0] ctrl_byte(input logic [4:0] blk, input logic rwb);
        return {blk, rwb, 2'b00};
    endfunction

endpackage

// File: rtl/w5500_spi_frame.sv
// One W5500 SPI frame: chip select, 3 header bytes, nbytes data bytes pulled
// on demand from the owner, then a minimum CS-high gap before the next frame.
module w5500_spi_frame
    import w5500_pkg::*;
#(
    parameter int CS_GAP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [7:0]  ctrl,
    input  logic [15:0] nbytes,
    output logic        ready,
    output logic        done,
    output logic        data_req,
    input  logic        data_vld,
    input  logic [7:0]  data_byte,
    output logic [15:0] data_idx,
    output logic        rx_vld,
    output logic [7:0]  rx_byte,
    output logic [15:0] rx_idx,
    output logic        spi_cs_n,
    output logic        spi_vld,
    output logic [7:0]  spi_byte,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx
);

    frame_state_t st_reg, st_next;
    logic [15:0]  addr_reg, nb_reg, dcnt_reg, gap_reg;
    logic [7:0]   ctrl_reg, byte_reg;
    logic [1:0]   hcnt_reg;
    logic         cs_n_reg, vld_reg, done_reg;
    logic         byte_done, last_byte;

    // hcnt: 0..2 = header byte on the wire, 3 = data phase
    assign byte_done = (st_reg == FR_BYTE) && spi_done;
    assign last_byte = (hcnt_reg == 2'd2 && nb_reg == 16'd0) ||
                       (hcnt_reg == 2'd3 && dcnt_reg == nb_reg);

    assign ready    = (st_reg == FR_IDLE);
    assign done     = done_reg;
    assign data_req = byte_done && !last_byte && hcnt_reg[1];
    assign data_idx = dcnt_reg;
    assign rx_vld   = byte_done && (hcnt_reg == 2'd3);
    assign rx_byte  = spi_rx;
    assign rx_idx   = dcnt_reg - 16'd1;
    assign spi_cs_n = cs_n_reg;
    assign spi_vld  = vld_reg;
    assign spi_byte = byte_reg;

    always_comb begin
        st_next = st_reg;
        case (st_reg)
            FR_IDLE:  if (start) st_next = FR_SETUP;
            FR_SETUP: st_next = FR_BYTE;
            FR_BYTE: begin
                if (byte_done) begin
                    if (last_byte)        st_next = FR_GAP;
                    else if (hcnt_reg[1]) st_next = FR_WAIT;
                end
            end
            FR_WAIT:  if (data_vld) st_next = FR_BYTE;
            FR_GAP:   if (gap_reg == 16'(CS_GAP - 1)) st_next = FR_IDLE;
            default:  st_next = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_reg <= FR_IDLE;
        else        st_reg <= st_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= 16'd0;
            nb_reg   <= 16'd0;
            dcnt_reg <= 16'd0;
            gap_reg  <= 16'd0;
            ctrl_reg <= 8'd0;
            byte_reg <= 8'd0;
            hcnt_reg <= 2'd0;
            cs_n_reg <= 1'b1;
            vld_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (st_reg)
                FR_IDLE: begin
                    if (start) begin
                        addr_reg <= addr;
                        ctrl_reg <= ctrl;
                        nb_reg   <= nbytes;
                        cs_n_reg <= 1'b0;
                    end
                end
                FR_SETUP: begin
                    vld_reg  <= 1'b1;
                    byte_reg <= addr_reg[15:8];
                    hcnt_reg <= 2'd0;
                    dcnt_reg <= 16'd0;
                end
                FR_BYTE: begin
                    if (byte_done) begin
                        if (last_byte) begin
                            vld_reg  <= 1'b0;
                            cs_n_reg <= 1'b1;
                            done_reg <= 1'b1;
                            gap_reg  <= 16'd0;
                        end else if (hcnt_reg == 2'd0) begin
                            byte_reg <= addr_reg[7:0];
                            hcnt_reg <= 2'd1;
                        end else if (hcnt_reg == 2'd1) begin
                            byte_reg <= ctrl_reg;
                            hcnt_reg <= 2'd2;
                        end else begin
                            vld_reg  <= 1'b0;
                            hcnt_reg <= 2'd3;
                        end
                    end
                end
                FR_WAIT: begin
                    if (data_vld) begin
                        byte_reg <= data_byte;
                        vld_reg  <= 1'b1;
                        dcnt_reg <= dcnt_reg + 16'd1;
                    end
                end
                FR_GAP:  gap_reg <= gap_reg + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/w5500_tx_ctrl.sv
// Transmit controller: copies a frame from the producer RAM into a W5500
// socket TX buffer, advances Sn_TX_WR, issues SEND and polls for completion.
module w5500_tx_ctrl
    import w5500_pkg::*;
#(
    parameter int SOCK     = 0,
    parameter int CS_GAP   = 4,
    parameter int POLL_MAX = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_dat_tx_req,
    input  logic [15:0] i_dat_len,
    output logic        o_dat_tx_rden,
    input  logic [7:0]  i_dat,
    output logic        o_dat_tx_end,
    output logic        o_spi_cs_n,
    output logic        o_spi_vld,
    output logic [7:0]  o_spi_byte,
    input  logic        i_spi_done,
    input  logic [7:0]  i_spi_rx,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [4:0] SOCK_BLK = bsb(3'(SOCK), SEL_SOCK_REG);
    localparam logic [4:0] TXB_BLK  = bsb(3'(SOCK), SEL_TX_BUF);

    tx_state_t   state_reg, state_next;
    logic [15:0] len_reg, ptr_reg, poll_cnt_reg;
    logic [7:0]  clr_reg;
    logic        req_d_reg, err_reg, frm_act_reg;
    logic        rden_reg, rd_d_reg, resp_reg;
    logic        ir_ok_reg, ir_to_reg;

    logic        frm_start, frm_ready, frm_done, frm_data_req, frm_data_vld;
    logic        frm_rx_vld;
    logic [15:0] frm_addr, frm_nb, frm_data_idx, frm_rx_idx;
    logic [7:0]  frm_ctrl, frm_data_byte, frm_rx_byte, fill_byte;
    logic [15:0] new_ptr;
    logic        req_rise, poll_last;

    assign req_rise  = i_dat_tx_req && !req_d_reg;
    assign new_ptr   = ptr_reg + len_reg;
    assign poll_last = (poll_cnt_reg == 16'(POLL_MAX - 1));

    // Payload bytes come from the producer RAM; every other data byte is local.
    assign frm_data_vld  = rd_d_reg | resp_reg;
    assign frm_data_byte = (state_reg == ST_WR_DATA) ? i_dat : fill_byte;

    assign o_dat_tx_rden = rden_reg;
    assign o_busy        = (state_reg != ST_IDLE);
    assign o_err         = err_reg;

    always_comb begin
        state_next   = state_reg;
        frm_addr     = SN_TX_WR;
        frm_ctrl     = ctrl_byte(SOCK_BLK, RWB_READ);
        frm_nb       = 16'd1;
        fill_byte    = 8'h00;
        o_dat_tx_end = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_rise) state_next = (i_dat_len == 16'd0) ? ST_DONE : ST_RD_PTR;
            end
            ST_RD_PTR: begin
                frm_nb = 16'd2;
                if (frm_done) state_next = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                frm_addr = ptr_reg;
                frm_ctrl = ctrl_byte(TXB_BLK, RWB_WRITE);
                frm_nb   = len_reg;
                if (frm_done) state_next = ST_WR_PTR;
            end
            ST_WR_PTR: begin
                frm_ctrl  = ctrl_byte(SOCK_BLK, RWB_WRITE);
                frm_nb    = 16'd2;
                fill_byte = (frm_data_idx == 16'd0) ? new_ptr[15:8] : new_ptr[7:0];
                if (frm_done) state_next = ST_WR_CMD;
            end
            ST_WR_CMD: begin
                frm_addr  = SN_CR;
                frm_ctrl  = ctrl_byte(SOCK_BLK, RWB_WRITE);
                fill_byte = CMD_SEND;
                if (frm_done) state_next = ST_POLL;
            end
            ST_POLL: begin
                frm_addr = SN_IR;
                if (frm_done) begin
                    if (ir_ok_reg || ir_to_reg) state_next = ST_CLR_IR;
                    else if (poll_last)         state_next = ST_DONE;
                end
            end
            ST_CLR_IR: begin
                frm_addr  = SN_IR;
                frm_ctrl  = ctrl_byte(SOCK_BLK, RWB_WRITE);
                fill_byte = clr_reg;
                if (frm_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                o_dat_tx_end = 1'b1;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // One frame per state visit; a repeated POLL re-arms once the frame has finished.
    assign frm_start = (state_reg != ST_IDLE) && (state_reg != ST_DONE) &&
                       !frm_act_reg && frm_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg      <= 16'd0;
            ptr_reg      <= 16'd0;
            poll_cnt_reg <= 16'd0;
            clr_reg      <= 8'd0;
            req_d_reg    <= 1'b0;
            err_reg      <= 1'b0;
            frm_act_reg  <= 1'b0;
            rden_reg     <= 1'b0;
            rd_d_reg     <= 1'b0;
            resp_reg     <= 1'b0;
            ir_ok_reg    <= 1'b0;
            ir_to_reg    <= 1'b0;
        end else begin
            req_d_reg <= i_dat_tx_req;
            rden_reg  <= frm_data_req && (state_reg == ST_WR_DATA);
            rd_d_reg  <= rden_reg;
            resp_reg  <= frm_data_req && (state_reg != ST_WR_DATA);
            if (frm_start)     frm_act_reg <= 1'b1;
            else if (frm_done) frm_act_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_rise) begin
                        len_reg      <= i_dat_len;
                        err_reg      <= 1'b0;
                        poll_cnt_reg <= 16'd0;
                    end
                end
                ST_RD_PTR: begin
                    if (frm_rx_vld) begin
                        if (frm_rx_idx == 16'd0) ptr_reg[15:8] <= frm_rx_byte;
                        else                     ptr_reg[7:0]  <= frm_rx_byte;
                    end
                end
                ST_POLL: begin
                    if (frm_rx_vld) begin
                        ir_ok_reg <= frm_rx_byte[IR_SEND_OK];
                        ir_to_reg <= frm_rx_byte[IR_TIMEOUT];
                    end
                    if (frm_done) begin
                        if (ir_ok_reg) begin
                            clr_reg <= 8'h10;
                        end else if (ir_to_reg) begin
                            clr_reg <= 8'h08;
                            err_reg <= 1'b1;
                        end else begin
                            poll_cnt_reg <= poll_cnt_reg + 16'd1;
                            if (poll_last) err_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    w5500_spi_frame #(.CS_GAP(CS_GAP)) u_frame (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (frm_start),
        .addr      (frm_addr),
        .ctrl      (frm_ctrl),
        .nbytes    (frm_nb),
        .ready     (frm_ready),
        .done      (frm_done),
        .data_req  (frm_data_req),
        .data_vld  (frm_data_vld),
        .data_byte (frm_data_byte),
        .data_idx  (frm_data_idx),
        .rx_vld    (frm_rx_vld),
        .rx_byte   (frm_rx_byte),
        .rx_idx    (frm_rx_idx),
        .spi_cs_n  (o_spi_cs_n),
        .spi_vld   (o_spi_vld),
        .spi_byte  (o_spi_byte),
        .spi_done  (i_spi_done),
        .spi_rx    (i_spi_rx)
    );

endmodule

// File: tb/tb_w5500_tx_ctrl.sv
// Directed bench for w5500_tx_ctrl: SPI slave/W5500 register model, producer
// RAM model and hand-written expected byte streams per transfer.
module tb_w5500_tx_ctrl;

    localparam int CS_GAP   = 4;
    localparam int POLL_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_dat_tx_req = 1'b0;
    logic [15:0] i_dat_len = 16'd0;
    logic [7:0]  i_dat = 8'd0;
    logic        i_spi_done = 1'b0;
    logic [7:0]  i_spi_rx = 8'd0;
    logic        o_dat_tx_rden, o_dat_tx_end, o_spi_cs_n, o_spi_vld, o_busy, o_err;
    logic [7:0]  o_spi_byte;

    w5500_tx_ctrl #(.SOCK(0), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_dat_tx_req  (i_dat_tx_req),
        .i_dat_len     (i_dat_len),
        .o_dat_tx_rden (o_dat_tx_rden),
        .i_dat         (i_dat),
        .o_dat_tx_end  (o_dat_tx_end),
        .o_spi_cs_n    (o_spi_cs_n),
        .o_spi_vld     (o_spi_vld),
        .o_spi_byte    (o_spi_byte),
        .i_spi_done    (i_spi_done),
        .i_spi_rx      (i_spi_rx),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:15];
    logic [15:0] txwr = 16'h0000;
    logic [7:0]  ir_seq [0:3];
    int          ir_n = 1;

    int          rd_addr = 0, poll_idx = 0, rden_cnt = 0, end_cnt = 0;
    int          cs_fall = 0, hi_run = 0, gap_min = 1000, pos = 0, spi_wait = 0;
    logic        cs_prev = 1'b1;
    logic [7:0]  fa_hi = 8'd0, fa_lo = 8'd0, fc = 8'd0;
    logic [7:0]  spi_log [$];

    // Producer RAM, SPI slave with W5500 register responses, and activity monitor.
    // All per-transfer bookkeeping clears while the request is low.
    always @(posedge clk) begin : model
        logic [7:0] rsp;
        i_spi_done <= 1'b0;
        cs_prev    <= o_spi_cs_n;
        hi_run     <= o_spi_cs_n ? hi_run + 1 : 0;
        if (!i_dat_tx_req) begin
            rd_addr  <= 0;
            poll_idx <= 0;
            rden_cnt <= 0;
            end_cnt  <= 0;
            cs_fall  <= 0;
            gap_min  <= 1000;
            spi_log.delete();
        end else begin
            if (o_dat_tx_rden) begin
                i_dat    <= mem[rd_addr & 15];
                rd_addr  <= rd_addr + 1;
                rden_cnt <= rden_cnt + 1;
            end
            if (o_dat_tx_end) end_cnt <= end_cnt + 1;
            if (cs_prev && !o_spi_cs_n) begin
                cs_fall <= cs_fall + 1;
                if (cs_fall > 0 && hi_run < gap_min) gap_min <= hi_run;
            end
        end
        if (o_spi_cs_n) begin
            pos      <= 0;
            spi_wait <= 0;
        end else if (o_spi_vld && !i_spi_done) begin
            if (spi_wait == 1) begin
                spi_wait   <= 0;
                i_spi_done <= 1'b1;
                pos        <= pos + 1;
                spi_log.push_back(o_spi_byte);
                if (pos == 0) fa_hi <= o_spi_byte;
                if (pos == 1) fa_lo <= o_spi_byte;
                if (pos == 2) fc    <= o_spi_byte;
                rsp = 8'h00;
                if (pos >= 3 && !fc[2]) begin
                    if ({fa_hi, fa_lo} == 16'h0024) begin
                        rsp = (pos == 3) ? txwr[15:8] : txwr[7:0];
                    end else if ({fa_hi, fa_lo} == 16'h0002) begin
                        rsp = (poll_idx < ir_n) ? ir_seq[poll_idx] : ir_seq[ir_n-1];
                        poll_idx <= poll_idx + 1;
                    end
                end
                i_spi_rx <= rsp;
            end else begin
                spi_wait <= spi_wait + 1;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // exp entries of -1 are bytes whose value is not defined (poll dummy byte).
    task automatic check_log(input string tag, input int exp[$]);
        int n;
        chk({tag, "_nbytes"}, spi_log.size(), exp.size());
        n = (spi_log.size() < exp.size()) ? spi_log.size() : exp.size();
        for (int i = 0; i < n; i++)
            if (exp[i] >= 0) chk($sformatf("%s_b%0d", tag, i), int'(spi_log[i]), exp[i]);
    endtask

    task automatic start_xfer(input logic [15:0] len);
        @(negedge clk);
        i_dat_len    = len;
        i_dat_tx_req = 1'b1;
    endtask

    task automatic wait_end(input string tag, input int tmo);
        int n = 0;
        while (end_cnt == 0 && n < tmo) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_end_seen"}, int'(end_cnt != 0), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic stop_xfer();
        @(negedge clk);
        i_dat_tx_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        int e1[$], e2[$], e3[$], e4[$], e5[$];
        e1 = '{'h00,'h24,'h08,'h00,'h00, 'h10,'h00,'h14,'hA1,'hB2,'hC3,
               'h00,'h24,'h0C,'h10,'h03, 'h00,'h01,'h0C,'h20,
               'h00,'h02,'h08,-1, 'h00,'h02,'h0C,'h10};
        e2 = '{'h00,'h24,'h08,'h00,'h00, 'hFF,'hFE,'h14,'h01,'h02,'h03,'h04,'h05,
               'h00,'h24,'h0C,'h00,'h03, 'h00,'h01,'h0C,'h20,
               'h00,'h02,'h08,-1, 'h00,'h02,'h0C,'h10};
        e3 = '{'h00,'h24,'h08,'h00,'h00, 'h01,'h00,'h14,'h5A,
               'h00,'h24,'h0C,'h01,'h01, 'h00,'h01,'h0C,'h20,
               'h00,'h02,'h08,-1, 'h00,'h02,'h08,-1, 'h00,'h02,'h08,-1,
               'h00,'h02,'h0C,'h10};
        e4 = '{'h00,'h24,'h08,'h00,'h00, 'h00,'h00,'h14,'h11,'h22,
               'h00,'h24,'h0C,'h00,'h02, 'h00,'h01,'h0C,'h20,
               'h00,'h02,'h08,-1, 'h00,'h02,'h0C,'h08};
        e5 = '{'h00,'h24,'h08,'h00,'h00, 'h02,'h00,'h14,'h77,
               'h00,'h24,'h0C,'h02,'h01, 'h00,'h01,'h0C,'h20,
               'h00,'h02,'h08,-1, 'h00,'h02,'h08,-1, 'h00,'h02,'h08,-1,
               'h00,'h02,'h08,-1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", o_spi_cs_n, 1);
        chk("rst_vld", o_spi_vld, 0);
        chk("rst_rden", o_dat_tx_rden, 0);
        chk("rst_tx_end", o_dat_tx_end, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal transfer, len=3
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
        txwr = 16'h1000; ir_seq[0] = 8'h10; ir_n = 1;
        start_xfer(16'd3);
        wait_end("t1", 3000);
        check_log("t1", e1);
        chk("t1_rden", rden_cnt, 3);
        chk("t1_end_cnt", end_cnt, 1);
        chk("t1_err", o_err, 0);
        chk("t1_busy", o_busy, 0);
        $display("xfer t1 len=3 bytes=%0d rden=%0d err=%0b", spi_log.size(), rden_cnt, o_err);
        stop_xfer();

        // Sn_TX_WR wrap
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04; mem[4] = 8'h05;
        txwr = 16'hFFFE; ir_seq[0] = 8'h10; ir_n = 1;
        start_xfer(16'd5);
        wait_end("t2", 3000);
        check_log("t2", e2);
        chk("t2_rden", rden_cnt, 5);
        chk("t2_err", o_err, 0);
        $display("xfer t2 len=5 bytes=%0d rden=%0d err=%0b", spi_log.size(), rden_cnt, o_err);
        stop_xfer();

        // Three polls before SEND_OK
        mem[0] = 8'h5A;
        txwr = 16'h0100; ir_seq[0] = 8'h00; ir_seq[1] = 8'h00; ir_seq[2] = 8'h10; ir_n = 3;
        start_xfer(16'd1);
        wait_end("t3", 3000);
        check_log("t3", e3);
        chk("t3_frames", cs_fall, 8);
        chk("t3_gap_ok", int'(gap_min >= CS_GAP), 1);
        chk("t3_err", o_err, 0);
        $display("xfer t3 len=1 bytes=%0d frames=%0d gap_min=%0d err=%0b", spi_log.size(), cs_fall, gap_min, o_err);
        stop_xfer();

        // W5500 reports TIMEOUT
        mem[0] = 8'h11; mem[1] = 8'h22;
        txwr = 16'h0000; ir_seq[0] = 8'h08; ir_n = 1;
        start_xfer(16'd2);
        wait_end("t4", 3000);
        check_log("t4", e4);
        chk("t4_err", o_err, 1);
        chk("t4_end_cnt", end_cnt, 1);
        $display("xfer t4 len=2 bytes=%0d err=%0b", spi_log.size(), o_err);
        stop_xfer();

        // Poll budget exhausted
        mem[0] = 8'h77;
        txwr = 16'h0200; ir_seq[0] = 8'h00; ir_n = 1;
        start_xfer(16'd1);
        wait_end("t5", 3000);
        check_log("t5", e5);
        chk("t5_frames", cs_fall, 8);
        chk("t5_err", o_err, 1);
        chk("t5_end_cnt", end_cnt, 1);
        $display("xfer t5 len=1 bytes=%0d frames=%0d err=%0b", spi_log.size(), cs_fall, o_err);
        stop_xfer();

        // len=0: immediate end, no SPI; held request must not restart
        start_xfer(16'd0);
        n = 0;
        while (!o_dat_tx_end && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("t6_end_latency_ok", int'(n >= 1 && n <= 2), 1);
        repeat (20) @(negedge clk);
        chk("t6_end_cnt", end_cnt, 1);
        chk("t6_no_cs", cs_fall, 0);
        chk("t6_no_bytes", spi_log.size(), 0);
        chk("t6_busy", o_busy, 0);
        chk("t6_err_cleared", o_err, 0);
        $display("xfer t6 len=0 latency=%0d end_cnt=%0d", n, end_cnt);
        stop_xfer();
        start_xfer(16'd0);
        wait_end("t6b", 20);
        stop_xfer();

        // Reset in the middle of WR_DATA
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
        txwr = 16'h1000; ir_seq[0] = 8'h10; ir_n = 1;
        start_xfer(16'd3);
        n = 0;
        while (rden_cnt == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t7_in_data", int'(rden_cnt != 0), 1);
        rst_n = 1'b0;
        #1;
        chk("t7_cs_n", o_spi_cs_n, 1);
        chk("t7_vld", o_spi_vld, 0);
        chk("t7_busy", o_busy, 0);
        chk("t7_tx_end", o_dat_tx_end, 0);
        repeat (3) @(negedge clk);
        chk("t7_no_end", end_cnt, 0);
        $display("xfer t7 reset mid-data rden=%0d end_cnt=%0d", rden_cnt, end_cnt);
        i_dat_tx_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/w5500_tx_ctrl.md
Name: w5500_tx_ctrl

Overview:
- Downstream consumer of the receive-buffer/processing stage.
- Takes a "frame ready" request plus byte length and pulls the bytes out of the processing stage's RAM through a read-enable strobe.
- Writes the bytes into the W5500 socket TX buffer over a byte-level SPI master, advances Sn_TX_WR, issues SEND, and waits for SEND_OK.
- Returns a one-cycle tx-end pulse to the producer.

Parameters:
SOCK, 0, W5500 socket index 0-7; socket-register BSB = SOCK*4+1, TX-buffer BSB = SOCK*4+2
CS_GAP, 4, minimum clk cycles o_spi_cs_n stays high between SPI frames (>=1)
POLL_MAX, 1000, maximum Sn_IR read frames before declaring failure

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_dat_tx_req  in  1  level request from producer; held high until after o_dat_tx_end
i_dat_len  in  16  payload byte count, stable while i_dat_tx_req high
o_dat_tx_rden  out  1  one-cycle read strobe to producer RAM; producer advances its read address per strobe
i_dat  in  8  RAM data, valid the cycle after o_dat_tx_rden
o_dat_tx_end  out  1  one-cycle pulse: transfer finished (success or error)
o_spi_cs_n  out  1  W5500 chip select, owned by this block
o_spi_vld  out  1  byte offered to SPI master; held until i_spi_done
o_spi_byte  out  8  byte to shift out
i_spi_done  in  1  one-cycle pulse: byte exchanged
i_spi_rx  in  8  byte shifted in, valid with i_spi_done
o_busy  out  1  high in every state except IDLE
o_err  out  1  sticky error flag; cleared at the start of the next transfer

Behaviour:
- Reset values: all outputs 0 except o_spi_cs_n=1; state=IDLE. Reset mid-transfer aborts immediately: CS high, no end pulse.
- Start: a rising edge of i_dat_tx_req in IDLE (registered edge detect) latches len=i_dat_len and clears o_err. A level held from the previous transfer does not restart it.
- SPI frame format:
  - addr_hi, addr_lo, ctrl={BSB[4:0], RWB, 2'b00 (VDM)}, then data phase.
  - CS falls one cycle before the first o_spi_vld and rises one cycle after the last i_spi_done.
  - Next frame starts no earlier than CS_GAP cycles later.
- Byte handshake: o_spi_vld/o_spi_byte are set; on the i_spi_done cycle the next byte is loaded the following cycle, or vld drops.
- States:
  - IDLE: len==0 at start -> DONE with no SPI activity; otherwise -> RD_PTR.
  - RD_PTR: read frame at 0x0024 (Sn_TX_WR), BSB socket, RWB=0, 2 dummy 0x00 data bytes. ptr={rx1,rx2}. -> WR_DATA.
  - WR_DATA: write frame at addr=ptr, BSB TX buffer, RWB=1, then len payload bytes.
    - For each byte: pulse o_dat_tx_rden, capture i_dat next cycle, present to SPI.
    - The next rden may be issued on the i_spi_done of the current byte (prefetch allowed). Exactly len strobes per transfer. -> WR_PTR.
  - WR_PTR: write 0x0024, 2 bytes, value (ptr+len) mod 2^16 (16-bit wrap, no saturation). -> WR_CMD.
  - WR_CMD: write 0x0001 (Sn_CR), byte 0x20 (SEND). -> POLL.
  - POLL: read 0x0002 (Sn_IR), 1 data byte.
    - bit4 (SEND_OK) set -> CLR_IR.
    - else bit3 (TIMEOUT) set -> o_err=1, CLR_IR.
    - else count++; count==POLL_MAX -> o_err=1, DONE; else repeat POLL after the CS gap.
  - CLR_IR: write 0x0002, byte = 0x10 on success / 0x08 on timeout. -> DONE.
  - DONE: o_dat_tx_end=1 for one cycle -> IDLE.
- The TX-buffer address wraps naturally within the W5500, so the block sends ptr unmodified; no split frames.
- i_spi_done outside an active byte is ignored.
- i_dat_tx_req falling mid-transfer is ignored; the transfer completes.

Decomposition:
- Shared package w5500_pkg:
  - register offsets SN_CR=0x0001, SN_IR=0x0002, SN_TX_WR=0x0024
  - command SEND=0x20; IR bits SEND_OK=4, TIMEOUT=3
  - BSB helper function (sock, sel)
  - state enum
- Sub-module w5500_spi_frame: sequences header, data phase and CS/CS_GAP timing for one frame.
  - Inputs: addr, ctrl, nbytes, start.
  - Per-byte data request/response; done strobe.
- Top FSM issues frames and handles data sourcing and results.

Test Plan:
- Reset: hold rst_n low -> cs_n=1, vld=0, rden=0, tx_end=0, busy=0; assert mid-WR_DATA -> cs_n=1 within the reset cycle, no tx_end.
- Normal, len=3, SOCK=0, Sn_TX_WR model=0x1000, data A1 B2 C3:
  - SPI bytes: 00 24 08 00 00 | 10 00 14 A1 B2 C3 | 00 24 0C 10 03 | 00 01 0C 20 | 00 02 08 xx | 00 02 0C 10.
  - Exactly 3 rden pulses; one tx_end; o_err=0.
- Pointer wrap: Sn_TX_WR=0xFFFE, len=5 -> WR_PTR writes 00 03; data frame addr FF FE.
- Poll: Sn_IR returns 0x00 twice then 0x10 -> 3 POLL frames each separated by >=CS_GAP cycles of cs_n=1; then CLR_IR writes 0x10.
- Errors:
  - Sn_IR=0x08 -> o_err=1, CLR_IR writes 0x08, tx_end pulses.
  - Sn_IR always 0 with POLL_MAX=4 -> 4 polls, o_err=1, tx_end, no CLR_IR.
- Request edge: len=0 -> tx_end 1-2 cycles after the req edge with no CS activity; req held high after tx_end -> no restart until req toggles low then high.
